// File: rtl/frame_vote_controller_if.sv
// rtl/frame_vote_controller_if.sv - camera/MCU-facing signal bundle of the frame vote controller
interface frame_vote_controller_if;
  logic       START;
  logic       VSYNC;
  logic [2:0] RESULT_IN;
  logic       OUT_ACK;
  logic       PROC_EN;
  logic       BUSY;
  logic       OUT_VALID;
  logic [2:0] OUT_RESULT;
  logic [3:0] OUT_VOTES;
  logic       LOW_CONF;
  logic       TIMEOUT;

  modport master (
    output START, VSYNC, RESULT_IN, OUT_ACK,
    input  PROC_EN, BUSY, OUT_VALID, OUT_RESULT, OUT_VOTES, LOW_CONF, TIMEOUT
  );

  modport slave (
    input  START, VSYNC, RESULT_IN, OUT_ACK,
    output PROC_EN, BUSY, OUT_VALID, OUT_RESULT, OUT_VOTES, LOW_CONF, TIMEOUT
  );
endinterface

// File: rtl/frame_vote_controller.sv
// rtl/frame_vote_controller.sv - majority vote of per-frame image codes for one MCU request
module frame_vote_controller #(
  parameter int NUM_FRAMES     = 5,
  parameter int SKIP_FRAMES    = 1,
  parameter int MIN_VOTES      = 3,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input logic                    CLK,
  input logic                    RESET_N,
  frame_vote_controller_if.slave bus
);
  localparam int               WD_W       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0]  WD_LAST    = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       FRAME_LAST = 4'(NUM_FRAMES - 1);
  localparam logic [1:0]       SKIP_LAST  = 2'(SKIP_FRAMES - 1);
  localparam logic [4:0]       MIN_V      = 5'(MIN_VOTES);

  typedef enum logic [2:0] {S_IDLE, S_SKIP, S_COLLECT, S_DECIDE, S_REPORT} state_t;

  state_t          state, state_nxt;
  logic            vsync_d, sample_pend;
  logic [1:0]      skip_cnt;
  logic [3:0]      frame_cnt;
  logic [WD_W-1:0] wd_cnt;
  logic [2:0]      scan_idx;
  logic [3:0]      tally [8];
  logic [3:0]      best_count, final_count;
  logic [2:0]      best_code, final_code;
  logic [2:0]      out_result;
  logic [3:0]      out_votes;
  logic            low_conf, timeout;
  logic            vs_rise, hunting, take_sample, last_sample, last_skip, wd_expired;

  assign vs_rise     = bus.VSYNC & ~vsync_d;
  assign hunting     = (state == S_SKIP) || (state == S_COLLECT);
  // sample_pend only arms on rises seen in COLLECT, so the frame that ends SKIP is never tallied
  assign take_sample = (state == S_COLLECT) && sample_pend;
  assign last_sample = take_sample && (frame_cnt == FRAME_LAST);
  assign last_skip   = (state == S_SKIP) && vs_rise && (skip_cnt == SKIP_LAST);
  assign wd_expired  = hunting && !vs_rise && (wd_cnt == WD_LAST);

  // strict greater-than keeps the lowest code on ties
  assign final_count = (tally[scan_idx] > best_count) ? tally[scan_idx] : best_count;
  assign final_code  = (tally[scan_idx] > best_count) ? scan_idx : best_code;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (bus.START) state_nxt = (SKIP_FRAMES > 0) ? S_SKIP : S_COLLECT;
      S_SKIP:    if (last_skip) state_nxt = S_COLLECT;
                 else if (wd_expired) state_nxt = S_REPORT;
      S_COLLECT: if (last_sample) state_nxt = S_DECIDE;
                 else if (wd_expired) state_nxt = S_REPORT;
      S_DECIDE:  if (scan_idx == 3'd7) state_nxt = S_REPORT;
      S_REPORT:  if (bus.OUT_ACK) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      vsync_d     <= 1'b0;
      sample_pend <= 1'b0;
      skip_cnt    <= '0;
      frame_cnt   <= '0;
      wd_cnt      <= '0;
      scan_idx    <= '0;
      best_count  <= '0;
      best_code   <= '0;
      for (int i = 0; i < 8; i++) tally[i] <= '0;
      out_result  <= '0;
      out_votes   <= '0;
      low_conf    <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      vsync_d     <= bus.VSYNC;
      sample_pend <= vs_rise && (state == S_COLLECT);
      case (state)
        S_IDLE: begin
          if (bus.START) begin
            skip_cnt   <= '0;
            frame_cnt  <= '0;
            wd_cnt     <= '0;
            scan_idx   <= '0;
            best_count <= '0;
            best_code  <= '0;
            for (int i = 0; i < 8; i++) tally[i] <= '0;
            out_result <= '0;
            out_votes  <= '0;
            low_conf   <= 1'b0;
            timeout    <= 1'b0;
          end
        end
        S_SKIP, S_COLLECT: begin
          wd_cnt <= vs_rise ? '0 : wd_cnt + 1'b1;
          if ((state == S_SKIP) && vs_rise) skip_cnt <= skip_cnt + 1'b1;
          if (take_sample) begin
            tally[bus.RESULT_IN] <= tally[bus.RESULT_IN] + 1'b1;
            frame_cnt            <= frame_cnt + 1'b1;
          end
          if (state_nxt == S_REPORT) begin
            out_result <= '0;
            out_votes  <= '0;
            low_conf   <= 1'b1;
            timeout    <= 1'b1;
          end
        end
        S_DECIDE: begin
          scan_idx   <= scan_idx + 1'b1;
          best_count <= final_count;
          best_code  <= final_code;
          if (scan_idx == 3'd7) begin
            out_votes  <= final_count;
            low_conf   <= ({1'b0, final_count} < MIN_V);
            out_result <= ({1'b0, final_count} < MIN_V) ? 3'd0 : final_code;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.PROC_EN    = hunting;
  assign bus.BUSY       = (state != S_IDLE);
  assign bus.OUT_VALID  = (state == S_REPORT);
  assign bus.OUT_RESULT = out_result;
  assign bus.OUT_VOTES  = out_votes;
  assign bus.LOW_CONF   = low_conf;
  assign bus.TIMEOUT    = timeout;
endmodule
